// File: rtl/is_uart_rx_param.sv
// is_uart_rx_param: oversampled UART receiver with a configurable data width,
// runtime parity/stop-bit selection, and parity, framing and break detection.
// Each bit is sampled once, at its middle, using the oversample tick count
// taken from the start-bit edge.
module is_uart_rx_param #(
    parameter int DATA_W = 8,
    parameter int OVS    = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              rxd_i,
    input  logic              tick_i,
    input  logic [2:0]        cfg_parity_i,
    input  logic              cfg_stop2_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              break_o,
    output logic              busy_o
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);

    localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP1     = 3'd4,
        S_STOP2     = 3'd5,
        S_WAIT_IDLE = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic              rxd_meta_q, rxd_s_q;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        cfg_par_q, cfg_par_d;
    logic              cfg_stop2_q, cfg_stop2_d;
    logic              par_err_q, par_err_d;
    logic              par_bit_q, par_bit_d;
    logic              stop1_q, stop1_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              perr_out_q, perr_out_d;
    logic              ferr_q, ferr_d;
    logic              brk_q, brk_d;

    logic rxd_s;
    logic half_done;
    logic bit_done;
    logic par_en;
    logic par_exp;
    logic frame_end;
    logic stop1_now;

    assign rxd_s     = rxd_s_q;
    assign half_done = tick_i && (tick_cnt_q == HALF_LAST);
    assign bit_done  = tick_i && (tick_cnt_q == BIT_LAST);
    // Modes 101..111 fall outside this range and therefore mean "no parity".
    assign par_en    = (cfg_par_q >= 3'd1) && (cfg_par_q <= 3'd4);
    assign frame_end = bit_done && (((state_q == S_STOP1) && !cfg_stop2_q) ||
                                    (state_q == S_STOP2));
    // With a single stop bit the first-stop sample is the one being taken now.
    assign stop1_now = (state_q == S_STOP1) ? rxd_s : stop1_q;

    // Expected parity bit for the latched mode over the assembled word.
    always_comb begin
        par_exp = 1'b0;
        case (cfg_par_q)
            3'd1:    par_exp = ^shift_q;
            3'd2:    par_exp = ~^shift_q;
            3'd3:    par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd_i;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every transition is qualified by an oversample tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (tick_i && !rxd_s) state_d = S_START;
            end
            S_START: begin
                if (half_done) state_d = rxd_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_done && (bit_cnt_q == DATA_LAST)) begin
                    state_d = par_en ? S_PARITY : S_STOP1;
                end
            end
            S_PARITY: begin
                if (bit_done) state_d = S_STOP1;
            end
            S_STOP1: begin
                if (bit_done) begin
                    if (cfg_stop2_q) state_d = S_STOP2;
                    else             state_d = rxd_s ? S_IDLE : S_WAIT_IDLE;
                end
            end
            S_STOP2: begin
                if (bit_done) state_d = rxd_s ? S_IDLE : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (tick_i && rxd_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: tick/bit counters, shifter, latched config and result capture.
    always_comb begin
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        cfg_par_d   = cfg_par_q;
        cfg_stop2_d = cfg_stop2_q;
        par_err_d   = par_err_q;
        par_bit_d   = par_bit_q;
        stop1_d     = stop1_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        perr_out_d  = perr_out_q;
        ferr_d      = ferr_q;
        brk_d       = brk_q;

        case (state_q)
            S_IDLE: begin
                if (tick_i && !rxd_s) begin
                    tick_cnt_d  = '0;
                    bit_cnt_d   = '0;
                    cfg_par_d   = cfg_parity_i;
                    cfg_stop2_d = cfg_stop2_i;
                    par_err_d   = 1'b0;
                    par_bit_d   = 1'b0;
                end
            end
            S_START: begin
                if (tick_i) tick_cnt_d = half_done ? '0 : tick_cnt_q + 1'b1;
            end
            S_DATA, S_PARITY, S_STOP1, S_STOP2: begin
                if (tick_i) tick_cnt_d = bit_done ? '0 : tick_cnt_q + 1'b1;
            end
            default: ;
        endcase

        if (bit_done && (state_q == S_DATA)) begin
            shift_d   = {rxd_s, shift_q[DATA_W-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (bit_done && (state_q == S_PARITY)) begin
            par_bit_d = rxd_s;
            par_err_d = (rxd_s != par_exp);
        end
        if (bit_done && (state_q == S_STOP1)) begin
            stop1_d = rxd_s;
        end
        if (frame_end) begin
            data_d     = shift_q;
            valid_d    = 1'b1;
            perr_out_d = par_err_q;
            ferr_d     = !rxd_s || ((state_q == S_STOP2) && !stop1_q);
            brk_d      = (shift_q == '0) && (!par_en || !par_bit_q) && !stop1_now;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            cfg_par_q   <= '0;
            cfg_stop2_q <= 1'b0;
            par_err_q   <= 1'b0;
            par_bit_q   <= 1'b0;
            stop1_q     <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_out_q  <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            cfg_par_q   <= cfg_par_d;
            cfg_stop2_q <= cfg_stop2_d;
            par_err_q   <= par_err_d;
            par_bit_q   <= par_bit_d;
            stop1_q     <= stop1_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_out_q  <= perr_out_d;
            ferr_q      <= ferr_d;
            brk_q       <= brk_d;
        end
    end

    // Output decode: busy everywhere except IDLE, results straight from flops.
    always_comb begin
        busy_o       = (state_q != S_IDLE);
        data_o       = data_q;
        valid_o      = valid_q;
        parity_err_o = perr_out_q;
        frame_err_o  = ferr_q;
        break_o      = brk_q;
    end

endmodule

// File: tb/tb_is_uart_rx_param.sv
// Directed bench for is_uart_rx_param: an 8-bit and a 7-bit receiver share
// clock, tick, reset and config, each on its own serial line.
module tb_is_uart_rx_param;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tick = 1'b0;
    logic       rxd8 = 1'b1;
    logic       rxd7 = 1'b1;
    logic [2:0] cfg_par = 3'b000;
    logic       cfg_stop2 = 1'b0;

    logic [7:0] d8;
    logic       v8, pe8, fe8, br8, bz8;
    logic [6:0] d7;
    logic       v7, pe7, fe7, br7, bz7;

    int tests = 0;
    int fails = 0;
    int vcnt8 = 0;
    int vcnt7 = 0;
    int base;

    is_uart_rx_param #(.DATA_W(8), .OVS(16)) dut8 (
        .clk_i(clk), .rstn_i(rstn), .rxd_i(rxd8), .tick_i(tick),
        .cfg_parity_i(cfg_par), .cfg_stop2_i(cfg_stop2),
        .data_o(d8), .valid_o(v8), .parity_err_o(pe8),
        .frame_err_o(fe8), .break_o(br8), .busy_o(bz8)
    );

    is_uart_rx_param #(.DATA_W(7), .OVS(16)) dut7 (
        .clk_i(clk), .rstn_i(rstn), .rxd_i(rxd7), .tick_i(tick),
        .cfg_parity_i(cfg_par), .cfg_stop2_i(cfg_stop2),
        .data_o(d7), .valid_o(v7), .parity_err_o(pe7),
        .frame_err_o(fe7), .break_o(br7), .busy_o(bz7)
    );

    always #5 clk = ~clk;

    // Oversample tick: one clk out of every four.
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    // Count valid pulses per receiver.
    always @(negedge clk) begin
        if (v8 === 1'b1) vcnt8++;
        if (v7 === 1'b1) vcnt7++;
    end

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge clk);
            if (tick) c++;
        end
        #2;
    endtask

    task automatic drive(input bit sel, input logic v, input int nbits);
        if (sel) rxd7 = v;
        else     rxd8 = v;
        wait_ticks(16 * nbits);
    endtask

    task automatic send_frame(input bit sel, input logic [8:0] data, input int nd,
                              input bit has_par, input logic par_bit,
                              input logic stop1, input bit two_stop, input logic stop2);
        $display("[TB] line%0d frame data=0x%0h par=%0d/%0b stop=%0b/%0d/%0b",
                 sel ? 7 : 8, data, has_par, par_bit, stop1, two_stop, stop2);
        drive(sel, 1'b0, 1);
        for (int i = 0; i < nd; i++) drive(sel, data[i], 1);
        if (has_par) drive(sel, par_bit, 1);
        drive(sel, stop1, 1);
        if (two_stop) drive(sel, stop2, 1);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (d8 !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", d8); end
        tests++; if (v8 !== 1'b0)  begin fails++; $display("FAIL reset_valid: got %b want 0", v8); end
        tests++; if (pe8 !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b want 0", pe8); end
        tests++; if (fe8 !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", fe8); end
        tests++; if (br8 !== 1'b0) begin fails++; $display("FAIL reset_brk: got %b want 0", br8); end
        tests++; if (bz8 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bz8); end
        tests++; if (bz7 !== 1'b0) begin fails++; $display("FAIL reset_busy7: got %b want 0", bz7); end
        @(posedge clk);
        #1 rstn = 1'b1;
        wait_ticks(4);
    endtask

    task automatic test_8n1;
        cfg_par = 3'b000; cfg_stop2 = 1'b0;
        base = vcnt8;
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        drive(0, 1'b1, 1);
        tests++; if (vcnt8 - base !== 1) begin fails++; $display("FAIL 8n1_count: got %0d want 1", vcnt8 - base); end
        tests++; if (d8 !== 8'hA5) begin fails++; $display("FAIL 8n1_data: got %h want a5", d8); end
        tests++; if ({pe8, fe8, br8} !== 3'b000) begin fails++; $display("FAIL 8n1_flags: got %b want 000", {pe8, fe8, br8}); end
        tests++; if (bz8 !== 1'b0) begin fails++; $display("FAIL 8n1_busy: got %b want 0", bz8); end
    endtask

    task automatic test_parity;
        // 0x03 has even weight: even parity expects 0, odd parity expects 1.
        cfg_par = 3'b001; cfg_stop2 = 1'b0;
        send_frame(0, 9'h003, 8, 1, 1'b1, 1'b1, 0, 1'b1);
        drive(0, 1'b1, 1);
        tests++; if (d8 !== 8'h03) begin fails++; $display("FAIL even_data: got %h want 03", d8); end
        tests++; if (pe8 !== 1'b1) begin fails++; $display("FAIL even_perr: got %b want 1", pe8); end
        tests++; if (fe8 !== 1'b0) begin fails++; $display("FAIL even_ferr: got %b want 0", fe8); end
        cfg_par = 3'b010;
        send_frame(0, 9'h003, 8, 1, 1'b1, 1'b1, 0, 1'b1);
        drive(0, 1'b1, 1);
        tests++; if (pe8 !== 1'b0) begin fails++; $display("FAIL odd_perr: got %b want 0", pe8); end
        tests++; if (d8 !== 8'h03) begin fails++; $display("FAIL odd_data: got %h want 03", d8); end
    endtask

    task automatic test_glitch;
        cfg_par = 3'b000; cfg_stop2 = 1'b0;
        base = vcnt8;
        $display("[TB] line8 glitch low 3 ticks");
        rxd8 = 1'b0;
        wait_ticks(3);
        rxd8 = 1'b1;
        wait_ticks(32);
        tests++; if (vcnt8 !== base) begin fails++; $display("FAIL glitch_novalid: got %0d want %0d", vcnt8, base); end
        tests++; if (bz8 !== 1'b0) begin fails++; $display("FAIL glitch_idle: got %b want 0", bz8); end
        send_frame(0, 9'h05A, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        drive(0, 1'b1, 1);
        tests++; if (vcnt8 - base !== 1) begin fails++; $display("FAIL glitch_count: got %0d want 1", vcnt8 - base); end
        tests++; if (d8 !== 8'h5A) begin fails++; $display("FAIL glitch_data: got %h want 5a", d8); end
    endtask

    task automatic test_stuck_low;
        base = vcnt8;
        send_frame(0, 9'h081, 8, 0, 1'b0, 1'b0, 0, 1'b0);
        tests++; if (vcnt8 - base !== 1) begin fails++; $display("FAIL stuck_count: got %0d want 1", vcnt8 - base); end
        tests++; if (d8 !== 8'h81) begin fails++; $display("FAIL stuck_data: got %h want 81", d8); end
        tests++; if (fe8 !== 1'b1) begin fails++; $display("FAIL stuck_ferr: got %b want 1", fe8); end
        tests++; if (br8 !== 1'b0) begin fails++; $display("FAIL stuck_brk: got %b want 0", br8); end
        drive(0, 1'b0, 20);
        tests++; if (vcnt8 - base !== 1) begin fails++; $display("FAIL stuck_hold: got %0d want 1", vcnt8 - base); end
        tests++; if (bz8 !== 1'b1) begin fails++; $display("FAIL stuck_busy: got %b want 1", bz8); end
        drive(0, 1'b1, 2);
        tests++; if (bz8 !== 1'b0) begin fails++; $display("FAIL stuck_release: got %b want 0", bz8); end
    endtask

    task automatic test_break;
        base = vcnt8;
        $display("[TB] line8 break low 12 bit times");
        drive(0, 1'b0, 12);
        tests++; if (vcnt8 - base !== 1) begin fails++; $display("FAIL brk_count: got %0d want 1", vcnt8 - base); end
        tests++; if (d8 !== 8'h00) begin fails++; $display("FAIL brk_data: got %h want 00", d8); end
        tests++; if (fe8 !== 1'b1) begin fails++; $display("FAIL brk_ferr: got %b want 1", fe8); end
        tests++; if (br8 !== 1'b1) begin fails++; $display("FAIL brk_flag: got %b want 1", br8); end
        tests++; if (bz8 !== 1'b1) begin fails++; $display("FAIL brk_wait: got %b want 1", bz8); end
        drive(0, 1'b1, 2);
        send_frame(0, 9'h033, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        drive(0, 1'b1, 1);
        tests++; if (vcnt8 - base !== 2) begin fails++; $display("FAIL brk_next_count: got %0d want 2", vcnt8 - base); end
        tests++; if (d8 !== 8'h33) begin fails++; $display("FAIL brk_next_data: got %h want 33", d8); end
        tests++; if ({pe8, fe8, br8} !== 3'b000) begin fails++; $display("FAIL brk_next_flags: got %b want 000", {pe8, fe8, br8}); end
    endtask

    task automatic test_back_to_back_7o2;
        // 0x41 has two ones -> odd parity bit 1; 0x7F has seven -> bit 0.
        cfg_par = 3'b010; cfg_stop2 = 1'b1;
        base = vcnt7;
        send_frame(1, 9'h041, 7, 1, 1'b1, 1'b1, 1, 1'b1);
        tests++; if (vcnt7 - base !== 1) begin fails++; $display("FAIL b2b_count1: got %0d want 1", vcnt7 - base); end
        tests++; if (d7 !== 7'h41) begin fails++; $display("FAIL b2b_data1: got %h want 41", d7); end
        tests++; if ({pe7, fe7, br7} !== 3'b000) begin fails++; $display("FAIL b2b_flags1: got %b want 000", {pe7, fe7, br7}); end
        send_frame(1, 9'h07F, 7, 1, 1'b0, 1'b1, 1, 1'b0);
        tests++; if (vcnt7 - base !== 2) begin fails++; $display("FAIL b2b_count2: got %0d want 2", vcnt7 - base); end
        tests++; if (d7 !== 7'h7F) begin fails++; $display("FAIL b2b_data2: got %h want 7f", d7); end
        tests++; if ({pe7, fe7, br7} !== 3'b010) begin fails++; $display("FAIL b2b_flags2: got %b want 010", {pe7, fe7, br7}); end
        drive(1, 1'b1, 2);
        tests++; if (bz7 !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b want 0", bz7); end
    endtask

    task automatic test_reset_mid_frame;
        base = vcnt7;
        $display("[TB] line7 partial frame then reset");
        drive(1, 1'b0, 1);
        drive(1, 1'b1, 1);
        drive(1, 1'b0, 1);
        rxd7 = 1'b0;
        wait_ticks(5);
        tests++; if (bz7 !== 1'b1) begin fails++; $display("FAIL rst_mid_busy: got %b want 1", bz7); end
        rstn = 1'b0;
        rxd7 = 1'b1;
        @(negedge clk);
        tests++; if (d7 !== 7'h00) begin fails++; $display("FAIL rst_mid_data7: got %h want 00", d7); end
        tests++; if ({v7, pe7, fe7, br7, bz7} !== 5'b0) begin fails++; $display("FAIL rst_mid_outs7: got %b want 00000", {v7, pe7, fe7, br7, bz7}); end
        tests++; if (d8 !== 8'h00) begin fails++; $display("FAIL rst_mid_data8: got %h want 00", d8); end
        wait_ticks(2);
        rstn = 1'b1;
        wait_ticks(16 * 12);
        tests++; if (vcnt7 !== base) begin fails++; $display("FAIL rst_mid_novalid: got %0d want %0d", vcnt7, base); end
        tests++; if (bz7 !== 1'b0) begin fails++; $display("FAIL rst_mid_idle: got %b want 0", bz7); end
        tests++; if (d7 !== 7'h00) begin fails++; $display("FAIL rst_mid_hold: got %h want 00", d7); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_stuck_low();
        test_break();
        test_back_to_back_7o2();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
